// File: rtl/prover_pkg.sv
// rtl/prover_pkg.sv - shared field parameters, modular helpers and fold FSM state encoding
package prover_pkg;

    localparam int F_NBITS = 16;

    typedef logic [F_NBITS-1:0] f_t;

    localparam f_t F_PRIME = 16'd65521;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EMIT,
        ST_WAIT_TAU,
        ST_FOLD,
        ST_DONE
    } fold_state_e;

    // Operands are assumed already reduced below F_PRIME.
    function automatic f_t f_add(input f_t a, input f_t b);
        logic [F_NBITS:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, F_PRIME}) begin
            s = s - {1'b0, F_PRIME};
        end
        return s[F_NBITS-1:0];
    endfunction

    function automatic f_t f_sub(input f_t a, input f_t b);
        f_t r;
        if (a >= b) begin
            r = a - b;
        end else begin
            r = a + (F_PRIME - b);
        end
        return r;
    endfunction

endpackage

// File: rtl/prover_compute_v_lane.sv
// rtl/prover_compute_v_lane.sv - one gate lane: 4-point evaluation of a pair and serial tau fold
module prover_compute_v_lane
    import prover_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear_i,
    input  logic                      cap_i,
    input  f_t                        e_i,
    input  f_t                        o_i,
    input  f_t                        tau_i,
    output logic [3:0][F_NBITS-1:0]   v_o,
    output f_t                        f_o,
    output logic                      done_o
);

    localparam int CW = $clog2(F_NBITS + 1);

    f_t            diff;
    f_t            v2;
    f_t            e_q;
    f_t            a_q;
    f_t            b_q;
    f_t            acc_q;
    logic [CW-1:0] cnt_q;
    logic          run_q;
    logic          done_q;

    always_comb begin
        diff   = f_sub(o_i, e_i);
        v2     = f_sub(f_add(o_i, o_i), e_i);
        v_o[0] = e_i;
        v_o[1] = o_i;
        v_o[2] = v2;
        v_o[3] = f_add(v2, diff);
    end

    // MSB-first double-and-add multiplier: one bit of (o-e) per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            e_q    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else if (clear_i) begin
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else if (cap_i) begin
            e_q    <= e_i;
            a_q    <= tau_i;
            b_q    <= diff;
            acc_q  <= '0;
            cnt_q  <= CW'(F_NBITS);
            run_q  <= 1'b1;
            done_q <= 1'b0;
        end else if (run_q) begin
            acc_q <= f_add(f_add(acc_q, acc_q), b_q[F_NBITS-1] ? a_q : '0);
            b_q   <= b_q << 1;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                run_q  <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

    assign f_o    = f_add(e_q, acc_q);
    assign done_o = done_q;

endmodule

// File: rtl/prover_compute_v_foldbank.sv
// rtl/prover_compute_v_foldbank.sv - runtime-sized V bank: emits pair evaluations per round, folds in place with tau
module prover_compute_v_foldbank
    import prover_pkg::*;
#(
    parameter int nCopyBits = 3,
    parameter int nParBits  = 1,
    parameter int nCopies   = 1 << nCopyBits,
    parameter int nParallel = 1 << nParBits
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic [$clog2(nCopyBits+1)-1:0]            n_rounds,
    input  logic [nCopies-1:0][F_NBITS-1:0]           in_vals,
    input  logic [F_NBITS-1:0]                        tau,
    input  logic                                      tau_valid,
    output logic                                      tau_ack,
    output logic [nParallel-1:0][3:0][F_NBITS-1:0]    out,
    output logic [nParallel-1:0]                      gates_en,
    input  logic [nParallel-1:0]                      gates_ready,
    output logic [F_NBITS-1:0]                        final_out,
    output logic                                      final_ready,
    output logic                                      ready_pulse,
    output logic                                      busy,
    output logic                                      err_cfg
);

    if (nCopyBits < 1 || nParBits < 0 || nParBits > nCopyBits - 1) begin : g_bad_par
        $error("prover_compute_v_foldbank: need nCopyBits>=1 and 0<=nParBits<=nCopyBits-1");
    end
    if (nCopies != (1 << nCopyBits) || nParallel != (1 << nParBits)) begin : g_bad_derived
        $error("prover_compute_v_foldbank: nCopies/nParallel are derived and must not be overridden");
    end

    typedef logic [nCopyBits-1:0]             idx_t;
    typedef logic [$clog2(nCopyBits+1)-1:0]   rnd_t;

    fold_state_e state_q, state_d;
    f_t          v_q [nCopies];
    f_t          v_d [nCopies];
    rnd_t        rounds_q, rounds_d;
    rnd_t        round_q, round_d;
    idx_t        batch_q, batch_d;
    logic        first_q, first_d;
    f_t          tau_q, tau_d;
    f_t          final_q, final_d;
    logic        err_q, err_d;
    logic        pulse_q, pulse_d;

    logic [nParallel-1:0]       lane_act;
    logic [nParallel-1:0]       lane_cap;
    logic [nParallel-1:0]       lane_done;
    f_t                         lane_e [nParallel];
    f_t                         lane_o [nParallel];
    f_t                         lane_f [nParallel];
    logic [3:0][F_NBITS-1:0]    lane_v [nParallel];

    int   pairs;
    int   nbatch;
    logic last_batch;

    // Lane k of the current batch owns pair i = batch*nParallel + k.
    always_comb begin
        int pidx;
        pidx       = 0;
        pairs      = (1 << rounds_q) >> (int'(round_q) + 1);
        nbatch     = (pairs + nParallel - 1) >> nParBits;
        last_batch = (int'(batch_q) + 1) >= nbatch;
        for (int k = 0; k < nParallel; k++) begin
            pidx        = int'(batch_q) * nParallel + k;
            lane_act[k] = pidx < pairs;
            lane_e[k]   = lane_act[k] ? v_q[idx_t'(2 * pidx)]     : '0;
            lane_o[k]   = lane_act[k] ? v_q[idx_t'(2 * pidx + 1)] : '0;
        end
    end

    for (genvar k = 0; k < nParallel; k++) begin : g_lane
        prover_compute_v_lane u_lane (
            .clk     (clk),
            .rst     (rst),
            .clear_i (start),
            .cap_i   (lane_cap[k]),
            .e_i     (lane_e[k]),
            .o_i     (lane_o[k]),
            .tau_i   (tau_q),
            .v_o     (lane_v[k]),
            .f_o     (lane_f[k]),
            .done_o  (lane_done[k])
        );
    end

    always_comb begin
        state_d  = state_q;
        v_d      = v_q;
        rounds_d = rounds_q;
        round_d  = round_q;
        batch_d  = batch_q;
        first_d  = first_q;
        tau_d    = tau_q;
        final_d  = final_q;
        err_d    = err_q;
        pulse_d  = 1'b0;
        gates_en = '0;
        tau_ack  = 1'b0;
        lane_cap = '0;

        case (state_q)
            ST_LOAD: begin
                if (rounds_q == '0) begin
                    state_d = ST_DONE;
                    final_d = v_q[0];
                    pulse_d = 1'b1;
                end else begin
                    state_d = ST_EMIT;
                    round_d = '0;
                    batch_d = '0;
                    first_d = 1'b1;
                end
            end
            ST_EMIT: begin
                if (first_q) begin
                    gates_en = lane_act;
                    first_d  = 1'b0;
                end else if ((gates_ready & lane_act) == lane_act) begin
                    if (last_batch) begin
                        state_d = ST_WAIT_TAU;
                    end else begin
                        batch_d = batch_q + 1'b1;
                        first_d = 1'b1;
                    end
                end
            end
            ST_WAIT_TAU: begin
                if (tau_valid) begin
                    tau_ack = 1'b1;
                    tau_d   = tau;
                    state_d = ST_FOLD;
                    batch_d = '0;
                    first_d = 1'b1;
                end
            end
            ST_FOLD: begin
                if (first_q) begin
                    lane_cap = lane_act;
                    first_d  = 1'b0;
                end else if ((lane_done & lane_act) == lane_act) begin
                    // Writes land at i, below every later batch's read index 2i.
                    for (int k = 0; k < nParallel; k++) begin
                        if (lane_act[k]) begin
                            v_d[idx_t'(int'(batch_q) * nParallel + k)] = lane_f[k];
                        end
                    end
                    first_d = 1'b1;
                    batch_d = batch_q + 1'b1;
                    if (last_batch) begin
                        batch_d = '0;
                        if ((round_q + 1'b1) == rounds_q) begin
                            state_d = ST_DONE;
                            final_d = lane_f[0];
                            pulse_d = 1'b1;
                        end else begin
                            state_d = ST_EMIT;
                            round_d = round_q + 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase

        if (start) begin
            state_d  = ST_LOAD;
            for (int c = 0; c < nCopies; c++) begin
                v_d[c] = in_vals[c];
            end
            rounds_d = (int'(n_rounds) > nCopyBits) ? rnd_t'(nCopyBits) : n_rounds;
            err_d    = int'(n_rounds) > nCopyBits;
            pulse_d  = 1'b0;
            gates_en = '0;
            tau_ack  = 1'b0;
            lane_cap = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            for (int c = 0; c < nCopies; c++) begin
                v_q[c] <= '0;
            end
            rounds_q <= '0;
            round_q  <= '0;
            batch_q  <= '0;
            first_q  <= 1'b0;
            tau_q    <= '0;
            final_q  <= '0;
            err_q    <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            v_q      <= v_d;
            rounds_q <= rounds_d;
            round_q  <= round_d;
            batch_q  <= batch_d;
            first_q  <= first_d;
            tau_q    <= tau_d;
            final_q  <= final_d;
            err_q    <= err_d;
            pulse_q  <= pulse_d;
        end
    end

    always_comb begin
        out = '0;
        if (state_q == ST_EMIT) begin
            for (int k = 0; k < nParallel; k++) begin
                out[k] = lane_v[k];
            end
        end
    end

    assign final_out   = final_q;
    assign final_ready = state_q == ST_DONE;
    assign ready_pulse = pulse_q;
    assign busy        = (state_q == ST_LOAD) || (state_q == ST_EMIT) ||
                         (state_q == ST_WAIT_TAU) || (state_q == ST_FOLD);
    assign err_cfg     = err_q;

endmodule

// File: tb/tb_prover_compute_v_foldbank.sv
// tb/tb_prover_compute_v_foldbank.sv - scoreboard bench for the fold bank (1-lane and 2-lane instances)
module tb_prover_compute_v_foldbank;

    localparam longint PR = 65521;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start0;
    logic                  start1;
    logic [1:0]            n_rounds;
    logic [3:0][15:0]      in_vals;
    logic [15:0]           tau;
    logic                  tau_valid;

    logic [0:0][3:0][15:0] out0;
    logic [0:0]            ge0;
    logic [0:0]            gr0 = '0;
    logic [15:0]           final0;
    logic                  fr0, pulse0, busy0, err0, ack0;

    logic [1:0][3:0][15:0] out1;
    logic [1:0]            ge1;
    logic [1:0]            gr1 = '0;
    logic [15:0]           final1;
    logic                  fr1, pulse1, busy1, err1, ack1;

    int cur_sel = 0;
    logic [1:0]       m_ge;
    logic [1:0][63:0] m_out;
    logic [15:0]      m_final;
    logic             m_fr, m_pulse, m_busy, m_err, m_ack;

    logic [63:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        gr0 <= ge0;
        gr1 <= ge1;
    end

    prover_compute_v_foldbank #(.nCopyBits(2), .nParBits(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .n_rounds(n_rounds), .in_vals(in_vals),
        .tau(tau), .tau_valid(tau_valid), .tau_ack(ack0), .out(out0), .gates_en(ge0),
        .gates_ready(gr0), .final_out(final0), .final_ready(fr0), .ready_pulse(pulse0),
        .busy(busy0), .err_cfg(err0)
    );

    prover_compute_v_foldbank #(.nCopyBits(2), .nParBits(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .n_rounds(n_rounds), .in_vals(in_vals),
        .tau(tau), .tau_valid(tau_valid), .tau_ack(ack1), .out(out1), .gates_en(ge1),
        .gates_ready(gr1), .final_out(final1), .final_ready(fr1), .ready_pulse(pulse1),
        .busy(busy1), .err_cfg(err1)
    );

    always_comb begin
        if (cur_sel == 1) begin
            m_ge = ge1; m_out = out1; m_final = final1; m_fr = fr1;
            m_pulse = pulse1; m_busy = busy1; m_err = err1; m_ack = ack1;
        end else begin
            m_ge = {1'b0, ge0}; m_out = {64'd0, out0[0]}; m_final = final0; m_fr = fr0;
            m_pulse = pulse0; m_busy = busy0; m_err = err0; m_ack = ack0;
        end
    end

    // Reference model: pushes every expected {v3,v2,v1,v0} in pair order, returns the folded value.
    function automatic logic [15:0] model_run(input logic [15:0] vals [4], input int r_cnt,
                                              input logic [15:0] taus [2]);
        longint v [4];
        longint nv [4];
        longint e, o, t;
        int     p;
        for (int i = 0; i < 4; i++) v[i] = longint'(vals[i]);
        for (int r = 0; r < r_cnt; r++) begin
            p = (1 << r_cnt) >> (r + 1);
            t = longint'(taus[r]);
            for (int i = 0; i < p; i++) begin
                e = v[2*i];
                o = v[2*i+1];
                exp_q.push_back({16'((3*o + 2*PR - 2*e) % PR), 16'((2*o + PR - e) % PR),
                                 16'(o), 16'(e)});
                nv[i] = (e + t * ((o + PR - e) % PR)) % PR;
            end
            for (int i = 0; i < p; i++) v[i] = nv[i];
        end
        return 16'(v[0]);
    endfunction

    task automatic run_case(input int sel, input logic [15:0] a0, a1, a2, a3, input logic [1:0] nr,
                            input logic [15:0] t0, t1, input logic [15:0] want_fin,
                            input logic want_err, output logic [1:0] first_ge);
        logic [15:0] vals [4];
        logic [15:0] taus [2];
        logic [15:0] mfin;
        logic [63:0] want;
        int  r_eff, n_ack, ti;
        bit  done, acked;
        r_eff    = (nr > 2'd2) ? 2 : int'(nr);
        vals     = '{a0, a1, a2, a3};
        taus     = '{t0, t1};
        first_ge = '0;
        exp_q.delete();
        mfin     = model_run(vals, r_eff, taus);
        @(posedge clk); #1;
        cur_sel   = sel;
        in_vals   = {a3, a2, a1, a0};
        n_rounds  = nr;
        tau       = t0;
        tau_valid = 1'b1;
        start0    = (sel == 0);
        start1    = (sel == 1);
        @(posedge clk); #1;
        start0 = 1'b0;
        start1 = 1'b0;
        checks++;
        if (m_fr !== 1'b0 || m_busy !== 1'b1 || m_ge !== 2'b00) begin
            errors++;
            $display("FAIL after_start: fr=%b busy=%b ge=%b want fr=0 busy=1 ge=00", m_fr, m_busy, m_ge);
        end
        n_ack = 0; ti = 0; done = 0;
        for (int c = 0; c < 2000 && !done; c++) begin
            @(negedge clk);
            if (m_ge != 2'b00 && first_ge == 2'b00) first_ge = m_ge;
            for (int k = 0; k < 2; k++) begin
                if (m_ge[k]) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL emit_extra lane%0d: got %h want no emission", k, m_out[k]);
                    end else begin
                        want = exp_q.pop_front();
                        if (m_out[k] !== want) begin
                            errors++;
                            $display("FAIL emit lane%0d: got %h want %h", k, m_out[k], want);
                        end
                    end
                end
            end
            acked = m_ack;
            if (acked) n_ack++;
            if (m_pulse) begin
                done = 1;
                checks++;
                if (m_final !== mfin || m_final !== want_fin || m_fr !== 1'b1 || m_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL final: got %0d fr=%b busy=%b want %0d (model %0d) fr=1 busy=0",
                             m_final, m_fr, m_busy, want_fin, mfin);
                end
            end
            @(posedge clk); #1;
            if (acked) begin
                ti++;
                tau = (ti < 2) ? taus[ti] : 16'd0;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL timeout: got no ready_pulse want ready_pulse within 2000 cycles");
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL emit_count: got %0d missing emissions want 0", exp_q.size());
        end
        checks++;
        if (n_ack != r_eff) begin
            errors++;
            $display("FAIL tau_ack_count: got %0d want %0d", n_ack, r_eff);
        end
        checks++;
        if (m_err !== want_err) begin
            errors++;
            $display("FAIL err_cfg: got %b want %b", m_err, want_err);
        end
        @(negedge clk);
        checks++;
        if (m_pulse !== 1'b0 || m_fr !== 1'b1 || m_final !== want_fin) begin
            errors++;
            $display("FAIL hold: pulse=%b fr=%b final=%0d want pulse=0 fr=1 final=%0d",
                     m_pulse, m_fr, m_final, want_fin);
        end
        tau_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start0 = 1'b1; start1 = 1'b1; tau_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start0 = 1'b0; start1 = 1'b0;
        @(negedge clk);
        checks++;
        if (m_ge !== 2'b00 || m_out !== '0 || m_final !== 16'd0 || m_fr !== 1'b0 || m_pulse !== 1'b0 ||
            m_busy !== 1'b0 || m_err !== 1'b0 || m_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset0: ge=%b final=%0d fr=%b pulse=%b busy=%b err=%b ack=%b want all 0",
                     m_ge, m_final, m_fr, m_pulse, m_busy, m_err, m_ack);
        end
        checks++;
        if (ge1 !== 2'b00 || busy1 !== 1'b0 || fr1 !== 1'b0 || ack1 !== 1'b0 || out1 !== '0) begin
            errors++;
            $display("FAIL reset1: ge=%b busy=%b fr=%b ack=%b want all 0", ge1, busy1, fr1, ack1);
        end
        @(posedge clk); #1;
        rst = 1'b0; tau_valid = 1'b0;
    endtask

    task automatic test_basic_serial();
        logic [1:0] fge;
        run_case(0, 16'd1, 16'd2, 16'd3, 16'd4, 2'd2, 16'd2, 16'd3, 16'd9, 1'b0, fge);
        checks++;
        if (fge !== 2'b01) begin
            errors++;
            $display("FAIL serial_gates_en: got %b want 01", fge);
        end
    endtask

    task automatic test_parallel();
        logic [1:0] fge;
        run_case(1, 16'd1, 16'd2, 16'd3, 16'd4, 2'd2, 16'd2, 16'd3, 16'd9, 1'b0, fge);
        checks++;
        if (fge !== 2'b11) begin
            errors++;
            $display("FAIL parallel_gates_en: got %b want 11", fge);
        end
        run_case(1, 16'd100, 16'd7, 16'd65520, 16'd3, 2'd2, 16'd40000, 16'd12345,
                 model_peek(), 1'b0, fge);
    endtask

    // Standalone model evaluation for a case whose result is not a hand constant.
    function automatic logic [15:0] model_peek();
        logic [15:0] vals [4];
        logic [15:0] taus [2];
        logic [15:0] r;
        vals = '{16'd100, 16'd7, 16'd65520, 16'd3};
        taus = '{16'd40000, 16'd12345};
        r = model_run(vals, 2, taus);
        exp_q.delete();
        return r;
    endfunction

    task automatic test_edge_values();
        logic [1:0] fge;
        run_case(0, 16'd5, 16'd1, 16'd0, 16'd0, 2'd1, 16'd0, 16'd0, 16'd5, 1'b0, fge);
        run_case(0, 16'd5, 16'd1, 16'd0, 16'd0, 2'd1, 16'd1, 16'd0, 16'd1, 1'b0, fge);
        run_case(1, 16'd5, 16'd1, 16'd0, 16'd0, 2'd1, 16'd1, 16'd0, 16'd1, 1'b0, fge);
        checks++;
        if (fge !== 2'b01) begin
            errors++;
            $display("FAIL single_pair_gates_en: got %b want 01", fge);
        end
    endtask

    task automatic test_zero_rounds();
        bit bad_evt;
        @(posedge clk); #1;
        cur_sel = 0; in_vals = {16'd9, 16'd8, 16'd7, 16'd42}; n_rounds = 2'd0;
        tau = 16'd7; tau_valid = 1'b1; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        @(negedge clk);
        bad_evt = (m_ge != 2'b00) || m_ack;
        checks++;
        if (m_fr !== 1'b0 || m_busy !== 1'b1) begin
            errors++;
            $display("FAIL r0_load: fr=%b busy=%b want fr=0 busy=1", m_fr, m_busy);
        end
        @(negedge clk);
        bad_evt = bad_evt || (m_ge != 2'b00) || m_ack;
        checks++;
        if (m_fr !== 1'b1 || m_pulse !== 1'b1 || m_final !== 16'd42) begin
            errors++;
            $display("FAIL r0_done: fr=%b pulse=%b final=%0d want fr=1 pulse=1 final=42",
                     m_fr, m_pulse, m_final);
        end
        repeat (3) begin
            @(negedge clk);
            bad_evt = bad_evt || (m_ge != 2'b00) || m_ack;
        end
        checks++;
        if (bad_evt || m_fr !== 1'b1 || m_pulse !== 1'b0) begin
            errors++;
            $display("FAIL r0_quiet: stray gates_en/tau_ack=%b fr=%b pulse=%b want 0,1,0", bad_evt, m_fr, m_pulse);
        end
        tau_valid = 1'b0;
    endtask

    task automatic test_err_cfg();
        logic [1:0] fge;
        run_case(0, 16'd1, 16'd2, 16'd3, 16'd4, 2'd3, 16'd2, 16'd3, 16'd9, 1'b1, fge);
        run_case(0, 16'd1, 16'd2, 16'd3, 16'd4, 2'd2, 16'd2, 16'd3, 16'd9, 1'b0, fge);
    endtask

    task automatic test_abort_restart();
        logic [1:0] fge;
        bit seen;
        @(posedge clk); #1;
        cur_sel = 0; in_vals = {16'd4, 16'd3, 16'd2, 16'd1}; n_rounds = 2'd2;
        tau = 16'd5; tau_valid = 1'b1; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        seen = 0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (m_ack) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL abort_setup: got no tau_ack want tau_ack within 200 cycles");
        end
        repeat (4) @(posedge clk);
        #1;
        run_case(0, 16'd9, 16'd8, 16'd7, 16'd6, 2'd1, 16'd2, 16'd0, 16'd7, 1'b0, fge);

        @(posedge clk); #1;
        in_vals = {16'd4, 16'd3, 16'd2, 16'd1}; n_rounds = 2'd2; tau_valid = 1'b1; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        seen = 0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            if (m_ge != 2'b00) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rst_setup: got no gates_en want gates_en within 50 cycles");
        end
        @(posedge clk); #1;
        rst = 1'b1; start0 = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start0 = 1'b0;
        @(negedge clk);
        checks++;
        if (m_ge !== 2'b00 || m_out !== '0 || m_ack !== 1'b0 || m_fr !== 1'b0 || m_busy !== 1'b0 ||
            m_pulse !== 1'b0 || m_err !== 1'b0 || m_final !== 16'd0) begin
            errors++;
            $display("FAIL rst_mid_emit: ge=%b ack=%b fr=%b busy=%b pulse=%b final=%0d want all 0",
                     m_ge, m_ack, m_fr, m_busy, m_pulse, m_final);
        end
        tau_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; tau_valid = 1'b0; tau = '0;
        n_rounds = '0; in_vals = '0;
        test_reset();
        test_basic_serial();
        test_parallel();
        test_edge_values();
        test_zero_rounds();
        test_err_cfg();
        test_abort_restart();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
